// File: rtl/pkt_tx_sequencer_pkg.sv
// Shared types and constants for the packet transmit sequencer.
package pkt_tx_sequencer_pkg;

   localparam int DWIDTH_DEF = 72;
   localparam int AWIDTH_DEF = 10;

   localparam logic [7:0] CTRL_SOP  = 8'hff;
   localparam logic [7:0] CTRL_BODY = 8'h00;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DROP   = 2'd2,
      ST_DONE   = 2'd3
   } tx_state_t;

endpackage

// File: rtl/pkt_tx_sequencer_out_skid_buf.sv
// Two-entry valid/ready skid buffer; entry 0 is always the word presented downstream.
module out_skid_buf
   import pkt_tx_sequencer_pkg::*;
#(
   parameter int W = DWIDTH_DEF
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic [1:0]   count
);

   logic         v0, v1;
   logic [W-1:0] d0, d1;
   logic         push, pop;

   assign in_ready  = ~v1;
   assign push      = in_valid & in_ready;
   assign pop       = v0 & out_ready;
   assign out_valid = v0;
   assign out_data  = d0;
   assign count     = {1'b0, v0} + {1'b0, v1};

   always_ff @(posedge clk) begin
      if (clr) begin
         v0 <= 1'b0;
         v1 <= 1'b0;
         d0 <= '0;
         d1 <= '0;
      end else if (pop) begin
         if (v1) begin
            d0 <= d1;
            v1 <= push;
            if (push) d1 <= in_data;
         end else begin
            v0 <= push;
            if (push) d0 <= in_data;
         end
      end else if (push) begin
         if (!v0) begin
            v0 <= 1'b1;
            d0 <= in_data;
         end else begin
            v1 <= 1'b1;
            d1 <= in_data;
         end
      end
   end

endmodule

// File: rtl/pkt_tx_sequencer.sv
// Streams a buffered packet (head_addr..end_addr, wrapping) to the output or drops it.
// Define TX_PKT_COUNT_EN to build the tx/drop packet counters.
module pkt_tx_sequencer
   import pkt_tx_sequencer_pkg::*;
#(
   parameter int DWIDTH = DWIDTH_DEF,
   parameter int AWIDTH = AWIDTH_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pc_en,
   input  logic              start,
   input  logic              drop,
   input  logic [AWIDTH-3:0] end_addr,
   input  logic              hold,
   output logic              rd_en,
   output logic [AWIDTH-3:0] rd_addr,
   input  logic [DWIDTH-1:0] rd_data,
   output logic [63:0]       out_data,
   output logic [7:0]        out_ctrl,
   output logic              out_wr,
   input  logic              out_rdy,
   output logic [AWIDTH-3:0] head_addr,
   output logic              busy,
   output logic              done,
   output logic [31:0]       tx_pkt_cnt,
   output logic [31:0]       drop_pkt_cnt
);

   localparam int BW = AWIDTH - 2;

   tx_state_t         state;
   logic [BW-1:0]     end_q, rd_ptr;
   logic              rd_last, rd_vld_pipe;
   logic              flush, xfer;
   logic [1:0]        skid_cnt;
   logic [2:0]        credit;
   logic              skid_in_ready;
   logic [DWIDTH-1:0] skid_data;

   assign flush = reset | ~pc_en;
   assign xfer  = out_wr & out_rdy;

   // Occupancy after this cycle's pop plus the read in flight; keeps 1 word/cycle with a 2-deep skid.
   assign credit  = {1'b0, skid_cnt} + {2'b0, rd_vld_pipe} - {2'b0, xfer};
   assign rd_en   = ~flush && (state == ST_STREAM) && ~hold && ~rd_last &&
                    (credit < 3'd2) && skid_in_ready;
   assign rd_addr = rd_ptr;

   assign out_data = skid_data[63:0];
   assign out_ctrl = skid_data[64 +: 8];

   out_skid_buf #(.W(DWIDTH)) u_skid (
      .clk       (clk),
      .clr       (flush),
      .in_valid  (rd_vld_pipe),
      .in_ready  (skid_in_ready),
      .in_data   (rd_data),
      .out_valid (out_wr),
      .out_ready (out_rdy),
      .out_data  (skid_data),
      .count     (skid_cnt)
   );

   always_ff @(posedge clk) begin
      if (flush) begin
         state       <= ST_IDLE;
         end_q       <= '0;
         rd_ptr      <= '0;
         rd_last     <= 1'b0;
         rd_vld_pipe <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         if (reset) head_addr <= '0;
      end else begin
         rd_vld_pipe <= rd_en;
         done        <= 1'b0;
         if (rd_en) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (rd_ptr == end_q) rd_last <= 1'b1;
         end
         case (state)
            ST_IDLE: if (start) begin
               end_q   <= end_addr;
               rd_ptr  <= head_addr;
               rd_last <= 1'b0;
               busy    <= 1'b1;
               state   <= drop ? ST_DROP : ST_STREAM;
            end
            ST_STREAM: if (xfer) begin
               head_addr <= head_addr + 1'b1;
               if (head_addr == end_q) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end
            end
            ST_DROP: begin
               head_addr <= end_q + 1'b1;
               state     <= ST_DONE;
               done      <= 1'b1;
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef TX_PKT_COUNT_EN
   logic last_xfer;
   assign last_xfer = (state == ST_STREAM) && xfer && (head_addr == end_q);

   // Counters survive pc_en=0; only reset clears them.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_pkt_cnt   <= '0;
         drop_pkt_cnt <= '0;
      end else if (pc_en) begin
         if (last_xfer)          tx_pkt_cnt   <= tx_pkt_cnt + 32'd1;
         if (state == ST_DROP)   drop_pkt_cnt <= drop_pkt_cnt + 32'd1;
      end
   end
`else
   assign tx_pkt_cnt   = '0;
   assign drop_pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_pkt_tx_sequencer.sv
// Randomized self-checking bench for pkt_tx_sequencer against a queue-based packet model.
module tb_pkt_tx_sequencer;
   import pkt_tx_sequencer_pkg::*;

   localparam int DW = 72;
   localparam int AW = 10;
   localparam int BW = AW - 2;
`ifdef TX_PKT_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset, pc_en, start, drop, hold, out_rdy;
   logic [BW-1:0] end_addr, rd_addr, head_addr;
   logic          rd_en, out_wr, busy, done;
   logic [DW-1:0] rd_data;
   logic [63:0]   out_data;
   logic [7:0]    out_ctrl;
   logic [31:0]   tx_pkt_cnt, drop_pkt_cnt;

   int checks = 0, failures = 0;
   logic [DW-1:0] mem [256];
   logic [DW-1:0] obs_q [$];
   int cyc_n = 0, start_cyc = 0, first_wr_cyc = -1;
   int done_cnt = 0, wr_cnt = 0, hold_rd_cnt = 0, stab_cnt = 0;
   logic          stall_q = 1'b0;
   logic [DW-1:0] stall_word = '0;
   logic [BW-1:0] ref_head = '0;
   int ref_tx = 0, ref_drop = 0;

   pkt_tx_sequencer #(.DWIDTH(DW), .AWIDTH(AW)) dut (
      .clk(clk), .reset(reset), .pc_en(pc_en), .start(start), .drop(drop),
      .end_addr(end_addr), .hold(hold), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data), .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr),
      .out_rdy(out_rdy), .head_addr(head_addr), .busy(busy), .done(done),
      .tx_pkt_cnt(tx_pkt_cnt), .drop_pkt_cnt(drop_pkt_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n++;
   always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

   // Passive observer: accepted words, done pulses, stall stability, reads under hold.
   always @(negedge clk) begin
      if (out_wr && first_wr_cyc < 0) first_wr_cyc = cyc_n;
      if (out_wr) wr_cnt++;
      if (out_wr && out_rdy && pc_en && !reset) obs_q.push_back({out_ctrl, out_data});
      if (done) done_cnt++;
      if (hold && rd_en) hold_rd_cnt++;
      if (stall_q && out_wr && ({out_ctrl, out_data} !== stall_word)) stab_cnt++;
      stall_q    = out_wr && !out_rdy && pc_en && !reset;
      stall_word = {out_ctrl, out_data};
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired at cycle %0d", cyc_n);
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   // Launch one packet and wait for its done pulse; rmode 0: rdy=1, 1: toggle, 2: random.
   task automatic run_pkt(input logic [BW-1:0] e, input bit d, input int rmode, output bit tmo);
      obs_q.delete(); done_cnt = 0; wr_cnt = 0; stab_cnt = 0; first_wr_cyc = -1;
      start_cyc = cyc_n; start = 1'b1; drop = d; end_addr = e; out_rdy = 1'b1;
      cyc();
      start = 1'b0; drop = 1'b0;
      tmo = 1'b1;
      for (int i = 0; i < 300; i++) begin
         case (rmode)
            1:       out_rdy = (i % 2 == 1);
            2:       out_rdy = 1'($urandom_range(0, 1));
            default: out_rdy = 1'b1;
         endcase
         cyc();
         if (done_cnt != 0) begin tmo = 1'b0; break; end
      end
      out_rdy = 1'b1;
      cyc(); cyc();
   endtask

   task automatic test_reset();
      reset = 1'b1; pc_en = 1'b1; start = 1'b0; drop = 1'b0; hold = 1'b0;
      out_rdy = 1'b1; end_addr = '0;
      repeat (3) cyc();
      reset = 1'b0;
      @(negedge clk);
      checks++; if (head_addr !== 8'h00) begin failures++; $display("FAIL rst_head got=%h exp=00", head_addr); end
      checks++; if (out_wr !== 1'b0) begin failures++; $display("FAIL rst_out_wr got=%b exp=0", out_wr); end
      checks++; if (rd_en !== 1'b0) begin failures++; $display("FAIL rst_rd_en got=%b exp=0", rd_en); end
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rst_busy_done got=%b%b exp=00", busy, done); end
      checks++; if ({out_ctrl, out_data} !== 72'h0) begin failures++; $display("FAIL rst_out_data got=%h exp=0", {out_ctrl, out_data}); end
      checks++; if (tx_pkt_cnt !== 32'd0 || drop_pkt_cnt !== 32'd0) begin failures++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", tx_pkt_cnt, drop_pkt_cnt); end
      ref_head = '0;
      cyc();
   endtask

   task automatic test_stream();
      bit tmo;
      run_pkt(8'h0F, 1'b1, 0, tmo);
      ref_head = 8'h10; ref_drop++;
      checks++; if (tmo || head_addr !== 8'h10) begin failures++; $display("FAIL A_prep_head got=%h exp=10 tmo=%0d", head_addr, tmo); end
      run_pkt(8'h13, 1'b0, 0, tmo);
      checks++; if (tmo) begin failures++; $display("FAIL A_timeout got=no_done exp=done"); end
      checks++; if (obs_q.size() != 4) begin failures++; $display("FAIL A_count got=%0d exp=4", obs_q.size()); end
      for (int i = 0; i < obs_q.size() && i < 4; i++) begin
         checks++;
         if (obs_q[i] !== mem[8'(ref_head + i)]) begin failures++; $display("FAIL A_word%0d got=%h exp=%h", i, obs_q[i], mem[8'(ref_head + i)]); end
      end
      checks++; if (first_wr_cyc - start_cyc != 3) begin failures++; $display("FAIL A_latency got=%0d exp=3", first_wr_cyc - start_cyc); end
      checks++; if (head_addr !== 8'h14) begin failures++; $display("FAIL A_head got=%h exp=14", head_addr); end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL A_done_pulses got=%0d exp=1", done_cnt); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL A_busy_after got=%b exp=0", busy); end
      ref_head = 8'h14; ref_tx++;
      checks++; if (tx_pkt_cnt !== 32'(CNT_EN ? ref_tx : 0)) begin failures++; $display("FAIL A_tx_cnt got=%0d exp=%0d", tx_pkt_cnt, CNT_EN ? ref_tx : 0); end
   endtask

   task automatic test_wrap();
      bit tmo;
      run_pkt(8'hFD, 1'b1, 0, tmo);
      ref_head = 8'hFE; ref_drop++;
      run_pkt(8'h01, 1'b0, 0, tmo);
      checks++; if (tmo || obs_q.size() != 4) begin failures++; $display("FAIL B_count got=%0d exp=4 tmo=%0d", obs_q.size(), tmo); end
      for (int i = 0; i < obs_q.size() && i < 4; i++) begin
         checks++;
         if (obs_q[i] !== mem[8'(ref_head + i)]) begin failures++; $display("FAIL B_word%0d got=%h exp=%h", i, obs_q[i], mem[8'(ref_head + i)]); end
      end
      checks++; if (head_addr !== 8'h02) begin failures++; $display("FAIL B_head got=%h exp=02", head_addr); end
      ref_head = 8'h02; ref_tx++;
   endtask

   task automatic test_drop();
      bit tmo;
      run_pkt(8'h20, 1'b1, 0, tmo);
      ref_drop++; ref_head = 8'h21;
      checks++; if (tmo || wr_cnt != 0) begin failures++; $display("FAIL C_out_wr got=%0d exp=0 tmo=%0d", wr_cnt, tmo); end
      checks++; if (head_addr !== 8'h21) begin failures++; $display("FAIL C_head got=%h exp=21", head_addr); end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL C_done_pulses got=%0d exp=1", done_cnt); end
      checks++; if (drop_pkt_cnt !== 32'(CNT_EN ? ref_drop : 0)) begin failures++; $display("FAIL C_drop_cnt got=%0d exp=%0d", drop_pkt_cnt, CNT_EN ? ref_drop : 0); end
   endtask

   task automatic test_backpressure();
      bit tmo;
      logic [BW-1:0] e;
      e = ref_head + 8'd5;
      run_pkt(e, 1'b0, 1, tmo);
      checks++; if (tmo || obs_q.size() != 6) begin failures++; $display("FAIL D_count got=%0d exp=6 tmo=%0d", obs_q.size(), tmo); end
      for (int i = 0; i < obs_q.size() && i < 6; i++) begin
         checks++;
         if (obs_q[i] !== mem[8'(ref_head + i)]) begin failures++; $display("FAIL D_word%0d got=%h exp=%h", i, obs_q[i], mem[8'(ref_head + i)]); end
      end
      checks++; if (stab_cnt != 0) begin failures++; $display("FAIL D_stall_stable got=%0d exp=0", stab_cnt); end
      ref_head = e + 8'd1; ref_tx++;
   endtask

   task automatic test_random();
      bit tmo, d;
      int len;
      logic [BW-1:0] e;
      for (int p = 0; p < 10; p++) begin
         len = $urandom_range(1, 12);
         d   = ($urandom_range(0, 3) == 0);
         e   = 8'(ref_head + len - 1);
         run_pkt(e, d, 2, tmo);
         checks++; if (tmo) begin failures++; $display("FAIL R%0d_timeout got=no_done exp=done", p); end
         if (d) begin
            checks++; if (wr_cnt != 0) begin failures++; $display("FAIL R%0d_drop_wr got=%0d exp=0", p, wr_cnt); end
            ref_drop++;
         end else begin
            checks++; if (obs_q.size() != len) begin failures++; $display("FAIL R%0d_count got=%0d exp=%0d", p, obs_q.size(), len); end
            for (int i = 0; i < obs_q.size() && i < len; i++) begin
               checks++;
               if (obs_q[i] !== mem[8'(ref_head + i)]) begin failures++; $display("FAIL R%0d_word%0d got=%h exp=%h", p, i, obs_q[i], mem[8'(ref_head + i)]); end
            end
            ref_tx++;
         end
         checks++; if (stab_cnt != 0) begin failures++; $display("FAIL R%0d_stall_stable got=%0d exp=0", p, stab_cnt); end
         ref_head = e + 8'd1;
         checks++; if (head_addr !== ref_head) begin failures++; $display("FAIL R%0d_head got=%h exp=%h", p, head_addr, ref_head); end
      end
      checks++; if (tx_pkt_cnt !== 32'(CNT_EN ? ref_tx : 0) || drop_pkt_cnt !== 32'(CNT_EN ? ref_drop : 0)) begin
         failures++; $display("FAIL R_cnts got=%0d/%0d exp=%0d/%0d", tx_pkt_cnt, drop_pkt_cnt, CNT_EN ? ref_tx : 0, CNT_EN ? ref_drop : 0);
      end
   endtask

   task automatic test_hold();
      bit tmo;
      logic [BW-1:0] e;
      e = ref_head + 8'd7;
      obs_q.delete(); done_cnt = 0; hold_rd_cnt = 0; stab_cnt = 0;
      start = 1'b1; drop = 1'b0; end_addr = e; out_rdy = 1'b1;
      cyc();
      start = 1'b0;
      cyc(); cyc();
      start = 1'b1; drop = 1'b1; end_addr = 8'h55; hold = 1'b1;
      cyc();
      start = 1'b0; drop = 1'b0;
      repeat (4) cyc();
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL F_busy_hold got=%b exp=1", busy); end
      hold = 1'b0;
      tmo = 1'b1;
      for (int i = 0; i < 200; i++) begin
         cyc();
         if (done_cnt != 0) begin tmo = 1'b0; break; end
      end
      cyc(); cyc();
      checks++; if (tmo) begin failures++; $display("FAIL F_timeout got=no_done exp=done"); end
      checks++; if (hold_rd_cnt != 0) begin failures++; $display("FAIL F_rd_in_hold got=%0d exp=0", hold_rd_cnt); end
      checks++; if (obs_q.size() != 8) begin failures++; $display("FAIL F_count got=%0d exp=8", obs_q.size()); end
      for (int i = 0; i < obs_q.size() && i < 8; i++) begin
         checks++;
         if (obs_q[i] !== mem[8'(ref_head + i)]) begin failures++; $display("FAIL F_word%0d got=%h exp=%h", i, obs_q[i], mem[8'(ref_head + i)]); end
      end
      ref_head = e + 8'd1; ref_tx++;
      checks++; if (head_addr !== ref_head || done_cnt != 1) begin failures++; $display("FAIL F_head_done got=%h/%0d exp=%h/1", head_addr, done_cnt, ref_head); end
   endtask

   task automatic test_pc_en();
      logic [BW-1:0] e;
      e = ref_head + 8'd7;
      obs_q.delete();
      start = 1'b1; drop = 1'b0; end_addr = e; out_rdy = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 50 && obs_q.size() < 3; i++) cyc();
      pc_en = 1'b0;
      cyc();
      @(negedge clk);
      checks++; if (out_wr !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL P_idle got=%b%b%b exp=000", out_wr, rd_en, busy); end
      checks++; if (head_addr !== 8'(ref_head + obs_q.size())) begin failures++; $display("FAIL P_head_kept got=%h exp=%h", head_addr, 8'(ref_head + obs_q.size())); end
      checks++; if (tx_pkt_cnt !== 32'(CNT_EN ? ref_tx : 0)) begin failures++; $display("FAIL P_cnt_kept got=%0d exp=%0d", tx_pkt_cnt, CNT_EN ? ref_tx : 0); end
      ref_head = 8'(ref_head + obs_q.size());
      pc_en = 1'b1;
      cyc();
   endtask

   task automatic test_reset_mid();
      logic [BW-1:0] e;
      e = ref_head + 8'd7;
      obs_q.delete();
      start = 1'b1; drop = 1'b0; end_addr = e; out_rdy = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 50 && obs_q.size() < 1; i++) cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      @(negedge clk);
      checks++; if (out_wr !== 1'b0 || rd_en !== 1'b0) begin failures++; $display("FAIL E_out_wr_rd_en got=%b%b exp=00", out_wr, rd_en); end
      checks++; if (head_addr !== 8'h00) begin failures++; $display("FAIL E_head got=%h exp=00", head_addr); end
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL E_busy_done got=%b%b exp=00", busy, done); end
      checks++; if ({out_ctrl, out_data} !== 72'h0) begin failures++; $display("FAIL E_out_data got=%h exp=0", {out_ctrl, out_data}); end
      checks++; if (tx_pkt_cnt !== 32'd0 || drop_pkt_cnt !== 32'd0) begin failures++; $display("FAIL E_cnt got=%0d/%0d exp=0/0", tx_pkt_cnt, drop_pkt_cnt); end
      wr_cnt = 0;
      repeat (6) cyc();
      checks++; if (wr_cnt != 0) begin failures++; $display("FAIL E_late_data got=%0d exp=0", wr_cnt); end
      ref_head = '0; ref_tx = 0; ref_drop = 0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++)
         mem[i] = {($urandom_range(0, 1) == 1) ? CTRL_SOP : CTRL_BODY, $urandom, $urandom};
      test_reset();
      test_stream();
      test_wrap();
      test_drop();
      test_backpressure();
      test_random();
      test_hold();
      test_pc_en();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pkt_tx_sequencer.md
PKT_TX_SEQUENCER -- requirements
Module: pkt_tx_sequencer

Interface
REQ-001 SHALL have parameter DWIDTH, default 72, meaning buffer word width (64 data + 8 ctrl).
REQ-002 SHALL have parameter AWIDTH, default 10, meaning system address width; buffer word address width is AWIDTH-2.
REQ-003 SHALL have port clk  input  1  sole clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pc_en  input  1  enable; low forces IDLE.
REQ-006 SHALL have port start  input  1  single-cycle pulse: processed packet ready to send.
REQ-007 SHALL have port drop  input  1  sampled with start; discard the packet.
REQ-008 SHALL have port end_addr  input  AWIDTH-2  address of the packet's last word, sampled with start.
REQ-009 SHALL have port hold  input  1  pauses new buffer reads.
REQ-010 SHALL have port rd_en / rd_addr  output  1 / AWIDTH-2  buffer read request; data returns one cycle later.
REQ-011 SHALL have port rd_data  input  DWIDTH  buffer read data.
REQ-012 SHALL have port out_data / out_ctrl / out_wr  output  64 / 8 / 1  output stream.
REQ-013 SHALL have port out_rdy  input  1  downstream accept.
REQ-014 SHALL have port head_addr  output  AWIDTH-2  next word to release; committed read pointer.
REQ-015 SHALL have ports busy / done  output  1 / 1  busy is the active level; done is a one-cycle completion pulse.
REQ-016 SHALL have ports tx_pkt_cnt / drop_pkt_cnt  output  32 / 32  statistics.

Function
REQ-017 SHALL implement states IDLE, STREAM, DROP, DONE.
REQ-018 IDLE with start=1, drop=1 SHALL latch end_addr and enter DROP.
REQ-019 IDLE with start=1, drop=0 SHALL latch end_addr and enter STREAM.
REQ-020 start SHALL be ignored outside IDLE.
REQ-021 DROP SHALL set head_addr = end_addr+1 (mod 2^(AWIDTH-2)) in one cycle, emit no out_wr, then enter DONE.
REQ-022 STREAM SHALL read addresses head_addr..end_addr inclusive, wrapping from all-ones to 0; head_addr==end_addr means a one-word packet.
REQ-023 rd_en SHALL assert only if hold=0 and (skid occupancy + reads in flight) < 2; no read beyond end_addr.
REQ-024 Returned words SHALL enter a 2-entry skid buffer; out_wr SHALL equal "skid non-empty".
REQ-025 A transfer SHALL occur when out_wr & out_rdy; on each transfer head_addr SHALL increment with wrap.
REQ-026 out_data/out_ctrl SHALL remain stable while out_wr=1 and out_rdy=0.
REQ-027 With out_rdy=1 and hold=0, the first out_wr SHALL occur 3 cycles after start, then 1 word/cycle.
REQ-028 After the transfer of the end_addr word, the block SHALL enter DONE; done SHALL pulse for one cycle; then return to IDLE.
REQ-029 busy SHALL be 1 from the cycle after start through the DONE cycle.
REQ-030 hold asserted mid-packet SHALL stop new reads; in-flight and buffered words SHALL still drain.

Reset
REQ-031 reset SHALL force: state IDLE, head_addr 0, rd_en 0, out_wr 0, out_data 0, out_ctrl 0, busy 0, done 0, skid empty, counters 0.
REQ-032 pc_en=0 SHALL apply the same as reset except that head_addr and the counters are retained.
REQ-033 reset mid-packet SHALL discard in-flight reads; the late rd_data SHALL be ignored.

Configuration
REQ-034 Macro TX_PKT_COUNT_EN defined: tx_pkt_cnt SHALL increment on each STREAM completion and drop_pkt_cnt on each DROP completion, wrapping at 2^32.
REQ-035 Macro TX_PKT_COUNT_EN undefined: both counter outputs SHALL be tied to 0 and no counter flops SHALL be present.

Structure
REQ-036 A shared package SHALL hold the state encodings, the DWIDTH/AWIDTH defaults, and the ctrl codes: SOP 8'hff, body 8'h00.
REQ-037 The skid buffer SHALL be sub-module out_skid_buf (2-entry, valid/ready).

Verification
REQ-038 Scenario A: head 0x10, end 0x13, out_rdy=1 -> 4 words, first out_wr at start+3, head ends 0x14, one done pulse.
REQ-039 Scenario B: head 0xFE, end 0x01 -> words from 0xFE, 0xFF, 0x00, 0x01 in order; head ends 0x02.
REQ-040 Scenario C: start with drop=1, end 0x20 -> no out_wr, head 0x21 next cycle, drop_pkt_cnt+1 (macro on).
REQ-041 Scenario D: out_rdy toggled 1010... during a 6-word packet -> no word lost or duplicated; data stable while stalled.
REQ-042 Scenario E: reset at the second word of an 8-word packet -> all outputs at reset values next cycle; the late rd_data is ignored.
REQ-043 Scenario F: start asserted while busy, and hold=1 for 5 cycles -> the extra start is ignored; no rd_en during hold; drain completes.
